// File: rtl/instruction_encoder.sv
// RV32I field-set encoder feeding a 2-entry output FIFO of {instruction, error}.
// Illegal field sets are stored as a NOP flagged with error and counted.
module instruction_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [6:0]  op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] imm_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] instruction_o,
    output logic        error_o,
    output logic [1:0]  count_o,
    output logic [7:0]  err_count_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] enc_word;
    logic [31:0] enc_instr;
    logic        enc_err;
    logic        imm12_ok, imm13_ok, imm21_ok, u_ok;

    logic [31:0] mem_instr [2];
    logic        mem_err   [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic [7:0]  err_count;
    logic        push, pop;

    // Range checks: the bits above the field's sign bit must all match it.
    assign imm12_ok = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
    assign imm13_ok = (imm_i[31:12] == '0) || (imm_i[31:12] == '1);
    assign imm21_ok = (imm_i[31:20] == '0) || (imm_i[31:20] == '1);
    assign u_ok     = (imm_i[31:19] == '0) || (imm_i[31:19] == '1);

    always_comb begin
        enc_word = NOP;
        enc_err  = 1'b0;
        case (op_i)
            7'h33: enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, op_i};
            7'h13: begin
                if (funct3_i == 3'b001 || funct3_i == 3'b101) begin
                    enc_word = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, op_i};
                    enc_err  = (imm_i[31:5] != '0);
                end else begin
                    enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
                    enc_err  = !imm12_ok;
                end
            end
            7'h03, 7'h67: begin
                enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
                enc_err  = !imm12_ok;
            end
            7'h23: begin
                enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
                enc_err  = !imm12_ok;
            end
            7'h63: begin
                enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], op_i};
                enc_err  = !imm13_ok || imm_i[0];
            end
            7'h37: begin
                enc_word = {imm_i[19:0], rd_i, op_i};
                enc_err  = !u_ok;
            end
            7'h6F: begin
                enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
                enc_err  = !imm21_ok || imm_i[0];
            end
            default: enc_err = 1'b1;
        endcase
        enc_instr = enc_err ? NOP : enc_word;
    end

    assign ready_o = (count != 2'd2);
    assign valid_o = (count != 2'd0);
    assign push    = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_instr[0] <= '0;
            mem_instr[1] <= '0;
            mem_err[0]   <= 1'b0;
            mem_err[1]   <= 1'b0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            count        <= 2'd0;
            err_count    <= 8'd0;
        end else begin
            if (push) begin
                mem_instr[wr_ptr] <= enc_instr;
                mem_err[wr_ptr]   <= enc_err;
                wr_ptr            <= !wr_ptr;
                if (enc_err && err_count != 8'hFF)
                    err_count <= err_count + 8'd1;
            end
            if (pop)
                rd_ptr <= !rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign instruction_o = mem_instr[rd_ptr];
    assign error_o       = mem_err[rd_ptr];
    assign count_o       = count;
    assign err_count_o   = err_count;

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 The block SHALL expose the following ports (clock and reset first):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low
- valid_i  input  1  field set presented
- ready_o  output  1  block can accept a field set
- op_i  input  7  opcode
- rd_i, rs1_i, rs2_i  input  5 each  register indices
- funct3_i  input  3  funct3
- funct7_i  input  7  funct7
- imm_i  input  32  signed byte-offset / immediate value
- valid_o  output  1  instruction_o holds an encoded word
- ready_i  input  1  consumer takes the word
- instruction_o  output  32  encoded RV32I word
- error_o  output  1  head word was produced from illegal fields
- count_o  output  2  FIFO occupancy, 0..2
- err_count_o  output  8  saturating count of encode errors

Function
REQ-003 A field set SHALL be accepted on any rising edge where valid_i && ready_o.
REQ-004 ready_o SHALL equal (count_o != 2); there is no same-cycle pass-through when full.
REQ-005 An accepted set SHALL be encoded combinationally and written into a 2-entry FIFO {instruction, error} on the accepting edge.
REQ-006 The FIFO head SHALL drive instruction_o and error_o, with valid_o = (count_o != 0); latency is 1 cycle from acceptance to valid_o when the FIFO is empty.
REQ-007 The head SHALL be popped on an edge where valid_o && ready_i; instruction_o and error_o SHALL stay stable while valid_o && !ready_i.
REQ-008 On a simultaneous push and pop, count_o SHALL be unchanged and the pushed word SHALL be queued behind the remaining entry, preserving FIFO order.
REQ-009 R-type (op 0x33): {funct7, rs2, rs1, funct3, rd, op}; never an error.
REQ-010 I-type (op 0x13, 0x03, 0x67): {imm[11:0], rs1, funct3, rd, op}; error if imm_i is outside [-2048, 2047].
REQ-011 Shift variant (op 0x13, funct3 001 or 101): {funct7, imm[4:0], rs1, funct3, rd, op}; error if imm_i[31:5] != 0.
REQ-012 S-type (op 0x23): {imm[11:5], rs2, rs1, funct3, imm[4:0], op}; error if imm_i is outside [-2048, 2047].
REQ-013 B-type (op 0x63): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}; error if imm_i is outside [-4096, 4094] or imm_i[0] = 1.
REQ-014 U-type (op 0x37): {imm[19:0], rd, op}; error if imm_i[31:20] is not the sign extension of imm_i[19].
REQ-015 J-type (op 0x6F): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}; error if imm_i is outside [-1048576, 1048574] or imm_i[0] = 1.
REQ-016 Any other opcode, and any error case above, SHALL store instruction 0x00000013 (NOP) with error = 1.
REQ-017 err_count_o SHALL increment by 1 on each accepted set that has error = 1, and SHALL saturate at 255.

Reset
REQ-018 When reset = 0 at a rising edge: count_o = 0, valid_o = 0, ready_o = 1, instruction_o = 0x00000000, error_o = 0, err_count_o = 0.
REQ-019 Reset SHALL discard all FIFO contents, including mid-handshake, and a push presented in the reset cycle SHALL be ignored.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- op 0x13, rd 1, rs1 0, funct3 0, imm 5 -> next cycle instruction_o = 0x00500093, error_o = 0.
- op 0x23, rs1 1, rs2 2, funct3 2, imm 8 -> 0x0020A423.
- op 0x63, rs1 0, rs2 0, funct3 0, imm -4 -> 0xFE000EE3; imm 3 -> 0x00000013, error_o = 1, err_count_o = 1.
- op 0x13, imm 2048 -> 0x00000013, error_o = 1; op 0x7F -> error_o = 1, err_count_o incremented.
- Backpressure: ready_i = 0, three back-to-back valid_i -> two accepted, count_o = 2, ready_o = 0; then ready_i = 1 -> words drain in order and the third set is accepted.
- Reset asserted with count_o = 2 -> all outputs at REQ-018 values next cycle, and err_count_o cleared.
